// File: rtl/mem_xfer_pkg.sv
// Shared types and defaults for the host-side memory transfer sequencer.
package mem_xfer_pkg;

  localparam int unsigned DATA_W         = 8;
  localparam int unsigned DEF_AW         = 8;
  localparam int unsigned DEF_LOAD_BASE  = 0;
  localparam int unsigned DEF_LOAD_LEN   = 64;
  localparam int unsigned DEF_DUMP_BASE  = 64;
  localparam int unsigned DEF_DUMP_LEN   = 64;
  localparam int unsigned DEF_TIMEOUT    = 4096;

  localparam int unsigned STATE_W = 3;
  localparam logic [STATE_W-1:0] S_IDLE = 3'd0;
  localparam logic [STATE_W-1:0] S_LOAD = 3'd1;
  localparam logic [STATE_W-1:0] S_REQ  = 3'd2;
  localparam logic [STATE_W-1:0] S_WAIT = 3'd3;
  localparam logic [STATE_W-1:0] S_DUMP = 3'd4;

  typedef enum logic [STATE_W-1:0] {
    XS_IDLE = S_IDLE,
    XS_LOAD = S_LOAD,
    XS_REQ  = S_REQ,
    XS_WAIT = S_WAIT,
    XS_DUMP = S_DUMP
  } xfer_state_t;

  // Watchdog counter width; one spare bit above the terminal count.
  function automatic int unsigned wd_width(input int unsigned timeout);
    return $clog2(timeout) + 1;
  endfunction

endpackage

// File: rtl/xfer_watchdog.sv
// Cycle counter for the WAIT phase; flags the cycle in which the budget runs out.
module xfer_watchdog
  import mem_xfer_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired_c
);

  localparam int unsigned WD_W = wd_width(TIMEOUT);

  logic [WD_W-1:0] r_wd;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wd <= '0;
    end else if (i_clr) begin
      r_wd <= '0;
    end else if (i_en) begin
      r_wd <= r_wd + WD_W'(1);
    end
  end

  assign o_expired_c = i_en && (r_wd == WD_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_xfer_ctrl.sv
// Host-side session sequencer: loads operands into data memory, runs the core,
// then streams results back out to the host.
module mem_xfer_ctrl
  import mem_xfer_pkg::*;
#(
  parameter int unsigned AW        = DEF_AW,
  parameter int unsigned LOAD_BASE = DEF_LOAD_BASE,
  parameter int unsigned LOAD_LEN  = DEF_LOAD_LEN,
  parameter int unsigned DUMP_BASE = DEF_DUMP_BASE,
  parameter int unsigned DUMP_LEN  = DEF_DUMP_LEN,
  parameter int unsigned TIMEOUT   = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              mem_wr_en,
  output logic [AW-1:0]     mem_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              cpu_req,
  input  logic              cpu_done,
  output logic              busy,
  output logic              timeout
);

  localparam int unsigned CNT_W = AW + 1;

  if (64'(LOAD_BASE) + 64'(LOAD_LEN) > (64'(1) << AW)) begin : g_bad_load
    $error("mem_xfer_ctrl: load range exceeds data memory");
  end
  if (64'(DUMP_BASE) + 64'(DUMP_LEN) > (64'(1) << AW)) begin : g_bad_dump
    $error("mem_xfer_ctrl: dump range exceeds data memory");
  end
  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("mem_xfer_ctrl: TIMEOUT must be at least 2");
  end

  xfer_state_t      r_state;
  xfer_state_t      w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_timeout;
  logic             w_timeout_nxt;
  logic             r_armed;
  logic             w_armed_nxt;
  logic             w_wd_clr;
  logic             w_wd_en;
  logic             w_wd_expired;
  logic             w_done_ok;

  xfer_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk         (clk),
    .reset       (reset),
    .i_clr       (w_wd_clr),
    .i_en        (w_wd_en),
    .o_expired_c (w_wd_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= XS_IDLE;
      r_cnt     <= '0;
      r_timeout <= 1'b0;
      r_armed   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_timeout <= w_timeout_nxt;
      r_armed   <= w_armed_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_timeout_nxt = r_timeout;
    w_armed_nxt   = r_armed;
    w_wd_clr      = 1'b0;
    w_wd_en       = 1'b0;
    w_done_ok     = 1'b0;

    in_ready    = 1'b0;
    mem_wr_en   = 1'b0;
    mem_wr_data = '0;
    mem_addr    = '0;
    out_valid   = 1'b0;
    out_data    = '0;
    cpu_req     = 1'b0;
    busy        = (r_state != XS_IDLE);
    timeout     = r_timeout;

    unique case (r_state)
      XS_IDLE: begin
        if (start) begin
          w_cnt_nxt     = '0;
          w_timeout_nxt = 1'b0;
          if (LOAD_LEN == 0) begin
            w_state_nxt = XS_REQ;
          end else begin
            w_state_nxt = XS_LOAD;
          end
        end
      end
      XS_LOAD: begin
        in_ready    = 1'b1;
        mem_wr_en   = in_valid;
        mem_wr_data = in_data;
        mem_addr    = AW'(LOAD_BASE) + r_cnt[AW-1:0];
        if (in_valid) begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(LOAD_LEN - 1)) begin
            w_cnt_nxt   = '0;
            w_state_nxt = XS_REQ;
          end
        end
      end
      XS_REQ: begin
        cpu_req     = 1'b1;
        w_wd_clr    = 1'b1;
        w_armed_nxt = 1'b0;
        w_state_nxt = XS_WAIT;
      end
      XS_WAIT: begin
        // A done level left over from the previous run is ignored until the
        // core has been seen to drop it at least once.
        w_wd_en     = 1'b1;
        w_armed_nxt = r_armed | ~cpu_done;
        w_done_ok   = cpu_done & r_armed;
        if (w_done_ok) begin
          w_cnt_nxt = '0;
          if (DUMP_LEN == 0) begin
            w_state_nxt = XS_IDLE;
          end else begin
            w_state_nxt = XS_DUMP;
          end
        end else if (w_wd_expired) begin
          w_cnt_nxt     = '0;
          w_timeout_nxt = 1'b1;
          w_state_nxt   = XS_IDLE;
        end
      end
      XS_DUMP: begin
        out_valid = 1'b1;
        out_data  = mem_rd_data;
        mem_addr  = AW'(DUMP_BASE) + r_cnt[AW-1:0];
        if (out_ready) begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(DUMP_LEN - 1)) begin
            w_cnt_nxt   = '0;
            w_state_nxt = XS_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = XS_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_xfer_ctrl.sv
// Self-checking bench for mem_xfer_ctrl: table-driven and randomized sessions
// against a session-level reference model, plus reset and zero-length corners.
module tb_mem_xfer_ctrl;

  localparam int unsigned AW = 8;
  localparam int unsigned LB = 0;
  localparam int unsigned LL = 4;
  localparam int unsigned DB = 64;
  localparam int unsigned DL = 4;
  localparam int unsigned TO = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance with a full load/run/dump session
  logic          reset, start, in_valid, in_ready, out_valid, out_ready;
  logic          mem_wr_en, cpu_req, cpu_done, busy, timeout;
  logic [7:0]    in_data, out_data, mem_wr_data, mem_rd_data;
  logic [AW-1:0] mem_addr;

  // Instance with both phases disabled
  logic          reset_z, start_z, in_valid_z, in_ready_z, out_valid_z;
  logic          mem_wr_en_z, cpu_req_z, cpu_done_z, busy_z, timeout_z;
  logic [7:0]    in_data_z, out_data_z, mem_wr_data_z;
  logic [AW-1:0] mem_addr_z;
  int            traffic_z = 0;

  logic [7:0]    mem [256];
  logic [7:0]    ref_mem [256];
  logic          tb_wr_en = 1'b0;
  logic [AW-1:0] tb_wr_addr = '0;
  logic [7:0]    tb_wr_data = '0;

  int n_chk = 0;
  int n_err = 0;
  bit last_to = 1'b0;

  typedef struct {
    int vmode;     // 0 always valid, 1 alternate, 2 random
    int rmode;     // 0 always ready, 1 pattern 1,0,0,1, 2 random
    int dly;       // WAIT cycle index at which done rises
    bit stale;     // done held high through REQ and WAIT
    bit exp_to;
    int exp_wait;  // WAIT cycles observed before leaving
  } vec_t;

  vec_t tbl [7];

  mem_xfer_ctrl #(
    .AW(AW), .LOAD_BASE(LB), .LOAD_LEN(LL), .DUMP_BASE(DB), .DUMP_LEN(DL), .TIMEOUT(TO)
  ) u_dut (
    .clk(clk), .reset(reset), .start(start),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
    .mem_rd_data(mem_rd_data), .cpu_req(cpu_req), .cpu_done(cpu_done),
    .busy(busy), .timeout(timeout)
  );

  mem_xfer_ctrl #(
    .AW(AW), .LOAD_BASE(0), .LOAD_LEN(0), .DUMP_BASE(64), .DUMP_LEN(0), .TIMEOUT(TO)
  ) u_dut_z (
    .clk(clk), .reset(reset_z), .start(start_z),
    .in_valid(in_valid_z), .in_data(in_data_z), .in_ready(in_ready_z),
    .out_valid(out_valid_z), .out_data(out_data_z), .out_ready(1'b1),
    .mem_wr_en(mem_wr_en_z), .mem_addr(mem_addr_z), .mem_wr_data(mem_wr_data_z),
    .mem_rd_data(8'h5A), .cpu_req(cpu_req_z), .cpu_done(cpu_done_z),
    .busy(busy_z), .timeout(timeout_z)
  );

  assign mem_rd_data = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_wr_en) mem[mem_addr] <= mem_wr_data;
    else if (tb_wr_en) mem[tb_wr_addr] <= tb_wr_data;
  end

  always @(posedge clk) begin
    if (!reset_z && (mem_wr_en_z || mem_addr_z != '0 || out_valid_z || mem_wr_data_z != '0))
      traffic_z <= traffic_z + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Session-level rule: done only counts after a WAIT cycle that saw it low;
  // otherwise the session ends after TO WAIT cycles with timeout set.
  function automatic void wait_model(input bit stale, input int dly,
                                     output int n_wait, output bit to);
    bit seen_low;
    bit d;
    seen_low = 1'b0;
    n_wait = TO;
    to = 1'b1;
    for (int w = 0; w < int'(TO); w++) begin
      d = stale ? 1'b1 : (w >= dly);
      if (d && seen_low) begin
        n_wait = w + 1;
        to = 1'b0;
        return;
      end
      if (!d) seen_low = 1'b1;
    end
  endfunction

  task automatic chk_idle(input string tag);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " in_ready"}, in_ready, 0);
    chk({tag, " out_valid"}, out_valid, 0);
    chk({tag, " out_data"}, out_data, 0);
    chk({tag, " mem_wr_en"}, mem_wr_en, 0);
    chk({tag, " mem_addr"}, mem_addr, 0);
    chk({tag, " mem_wr_data"}, mem_wr_data, 0);
    chk({tag, " cpu_req"}, cpu_req, 0);
    chk({tag, " timeout"}, timeout, 0);
  endtask

  task automatic preload();
    for (int i = 0; i < int'(DL); i++) begin
      @(negedge clk);
      tb_wr_en   = 1'b1;
      tb_wr_addr = AW'(DB + i);
      tb_wr_data = 8'($urandom);
      ref_mem[DB + i] = tb_wr_data;
    end
    @(negedge clk);
    tb_wr_en = 1'b0;
  endtask

  // Entered and left at a falling edge with the DUT idle.
  task automatic run_session(input int vmode, input int rmode, input int dly, input bit stale,
                             input bit exp_to, input int exp_wait, input string tag);
    int k, w, j, cyc;
    logic [3:0] rpat;
    rpat = 4'b1001;
    start = 1'b1; in_valid = 1'b0; out_ready = 1'b0; cpu_done = 1'b1;
    #1;
    chk({tag, " idle_busy"}, busy, 0);
    chk({tag, " sticky_timeout"}, timeout, 32'(last_to));
    @(negedge clk);
    start = 1'b0;
    #1;
    chk({tag, " timeout_cleared"}, timeout, 0);
    k = 0; cyc = 0;
    while (k < int'(LL) && cyc < 200) begin
      case (vmode)
        0:       in_valid = 1'b1;
        1:       in_valid = (cyc % 2 == 0);
        default: in_valid = 1'($urandom_range(0, 1));
      endcase
      in_data = 8'($urandom);
      #1;
      chk({tag, " load_ready"}, in_ready, 1);
      chk({tag, " load_busy"}, busy, 1);
      chk({tag, " load_wr_en"}, mem_wr_en, 32'(in_valid));
      chk({tag, " load_req"}, cpu_req, 0);
      if (in_valid) begin
        chk({tag, " load_addr"}, mem_addr, LB + k);
        chk({tag, " load_data"}, mem_wr_data, in_data);
        ref_mem[LB + k] = in_data;
        k++;
      end
      @(negedge clk);
      cyc++;
    end
    if (k < int'(LL)) chk({tag, " load_budget"}, k, LL);
    in_valid = 1'b1;
    cpu_done = stale;
    #1;
    chk({tag, " req_pulse"}, cpu_req, 1);
    chk({tag, " req_in_ready"}, in_ready, 0);
    chk({tag, " req_wr_en"}, mem_wr_en, 0);
    chk({tag, " req_addr"}, mem_addr, 0);
    @(negedge clk);
    w = 0;
    while (w < int'(TO) + 4) begin
      cpu_done = stale ? 1'b1 : (w >= dly);
      #1;
      if (!(busy && !out_valid)) break;
      chk({tag, " wait_req"}, cpu_req, 0);
      chk({tag, " wait_addr"}, mem_addr, 0);
      chk({tag, " wait_wr_en"}, mem_wr_en, 0);
      w++;
      @(negedge clk);
    end
    chk({tag, " wait_cycles"}, w, exp_wait);
    in_valid = 1'b0;
    if (exp_to) begin
      chk({tag, " abort_busy"}, busy, 0);
      chk({tag, " abort_timeout"}, timeout, 1);
      chk({tag, " abort_no_dump"}, out_valid, 0);
    end else begin
      j = 0; cyc = 0;
      while (j < int'(DL) && cyc < 200) begin
        chk({tag, " dump_valid"}, out_valid, 1);
        chk({tag, " dump_addr"}, mem_addr, DB + j);
        chk({tag, " dump_data"}, out_data, ref_mem[DB + j]);
        chk({tag, " dump_wr_en"}, mem_wr_en, 0);
        case (rmode)
          0:       out_ready = 1'b1;
          1:       out_ready = rpat[cyc % 4];
          default: out_ready = 1'($urandom_range(0, 1));
        endcase
        if (out_ready) j++;
        @(negedge clk);
        #1;
        cyc++;
      end
      chk({tag, " dump_end_valid"}, out_valid, 0);
      chk({tag, " dump_end_busy"}, busy, 0);
      chk({tag, " dump_end_timeout"}, timeout, 0);
    end
    for (int i = 0; i < int'(LL); i++)
      chk({tag, " mem_content"}, mem[LB + i], ref_mem[LB + i]);
    out_ready = 1'b0;
    last_to = exp_to;
    @(negedge clk);
  endtask

  initial begin
    int n_wait;
    bit to;
    int vm, rm, dl;
    bit st;

    tbl[0] = '{0, 0, 10, 1'b0, 1'b0, 11};
    tbl[1] = '{0, 1,  3, 1'b0, 1'b0,  4};
    tbl[2] = '{1, 0,  1, 1'b0, 1'b0,  2};
    tbl[3] = '{0, 0,  0, 1'b1, 1'b1, 16};
    tbl[4] = '{2, 2, 15, 1'b0, 1'b0, 16};
    tbl[5] = '{2, 2, 16, 1'b0, 1'b1, 16};
    tbl[6] = '{0, 0,  0, 1'b0, 1'b1, 16};

    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; cpu_done = 1'b1;
    reset_z = 1'b1; start_z = 1'b0; in_valid_z = 1'b0; in_data_z = 8'hA5; cpu_done_z = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk_idle("reset");
    chk("reset_z busy", busy_z, 0);
    chk("reset_z cpu_req", cpu_req_z, 0);
    reset = 1'b0; reset_z = 1'b0;
    @(negedge clk);

    preload();
    for (int i = 0; i < 7; i++)
      run_session(tbl[i].vmode, tbl[i].rmode, tbl[i].dly, tbl[i].stale,
                  tbl[i].exp_to, tbl[i].exp_wait, $sformatf("tbl%0d", i));

    // Reset in the middle of a load after two accepted bytes
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_data = 8'(8'hC0 + i);
      @(negedge clk);
    end
    in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    #1;
    chk_idle("midreset");
    chk("midreset kept0", mem[LB], 8'hC0);
    chk("midreset kept1", mem[LB + 1], 8'hC1);
    reset = 1'b0;
    last_to = 1'b0;
    @(negedge clk);
    run_session(0, 0, 5, 1'b0, 1'b0, 6, "after_reset");

    for (int r = 0; r < 12; r++) begin
      preload();
      vm = $urandom_range(0, 2);
      rm = $urandom_range(0, 2);
      dl = $urandom_range(0, 20);
      st = ($urandom_range(0, 7) == 0);
      wait_model(st, dl, n_wait, to);
      run_session(vm, rm, dl, st, to, n_wait, $sformatf("rnd%0d", r));
    end

    // Zero-length load and dump: start -> REQ -> WAIT -> IDLE, no memory traffic
    start_z = 1'b1; in_valid_z = 1'b1; cpu_done_z = 1'b1;
    #1;
    chk("zero idle_busy", busy_z, 0);
    @(negedge clk);
    start_z = 1'b0; cpu_done_z = 1'b0;
    #1;
    chk("zero req_pulse", cpu_req_z, 1);
    chk("zero in_ready", in_ready_z, 0);
    @(negedge clk);
    #1;
    chk("zero wait_req", cpu_req_z, 0);
    chk("zero wait_busy", busy_z, 1);
    @(negedge clk);
    cpu_done_z = 1'b1;
    #1;
    chk("zero wait1_busy", busy_z, 1);
    @(negedge clk);
    #1;
    chk("zero end_busy", busy_z, 0);
    chk("zero end_timeout", timeout_z, 0);
    chk("zero out_data", out_data_z, 0);
    chk("zero traffic", traffic_z, 0);
    in_valid_z = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/mem_xfer_ctrl.md
Name: mem_xfer_ctrl

Overview:
Host-side session sequencer for the 9-bit CPU core.
- Streams LOAD_LEN operand bytes from a host valid/ready channel into data memory.
- Issues a one-cycle req to the core, then waits for done or a watchdog timeout.
- Drains DUMP_LEN result bytes from data memory onto a host valid/ready output stream.
- Owns the data-memory port whenever the core is not running.

Parameters:
AW, 8, data memory address width
LOAD_BASE, 0, first address written in the load phase
LOAD_LEN, 64, bytes loaded (0 = skip load phase)
DUMP_BASE, 64, first address read in the dump phase
DUMP_LEN, 64, bytes dumped (0 = skip dump phase)
TIMEOUT, 4096, max cycles spent in WAIT before abort

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  begin a session; sampled only in IDLE
in_valid  in  1  host load byte valid
in_data  in  8  host load byte
in_ready  out  1  block accepts load byte
out_valid  out  1  result byte valid
out_data  out  8  result byte
out_ready  in  1  host accepts result byte
mem_wr_en  out  1  data memory write strobe
mem_addr  out  AW  data memory address
mem_wr_data  out  8  data memory write data
mem_rd_data  in  8  data memory read data, combinational from mem_addr
cpu_req  out  1  one-cycle run request to core
cpu_done  in  1  core done level
busy  out  1  session in progress (state != IDLE)
timeout  out  1  sticky: last session aborted by watchdog

Behaviour:
- Clock and reset: single clock clk; reset synchronous, active-high.
- Reset values: state IDLE; all outputs 0; counters 0; timeout 0. Reset mid-session aborts immediately; the memory contents already written are left as-is.
- States: IDLE, LOAD, REQ, WAIT, DUMP.
- IDLE:
  - start=1 goes to LOAD, or to REQ if LOAD_LEN=0.
  - On that transition: clear timeout and cnt.
- LOAD:
  - in_ready=1.
  - mem_addr = LOAD_BASE+cnt.
  - mem_wr_data = in_data.
  - mem_wr_en = in_valid & in_ready (combinational).
  - Each handshake increments cnt.
  - When the handshake with cnt==LOAD_LEN-1 completes, go to REQ next cycle; in_ready is 0 from that cycle on.
- REQ: cpu_req=1 for exactly one cycle. Clear the wd counter and the armed flag, then go to WAIT.
- WAIT:
  - Stale-done guard: armed sets the first cycle cpu_done==0 is seen. The exit on cpu_done==1 is taken only when armed is already 1.
  - Watchdog: wd increments every WAIT cycle.
  - If wd reaches TIMEOUT-1 without a valid done: set timeout=1 and go to IDLE, skipping dump.
  - If done and timeout occur in the same cycle, done wins.
  - Valid done goes to DUMP, or to IDLE if DUMP_LEN=0. cnt clears on exit.
- DUMP:
  - mem_addr = DUMP_BASE+cnt.
  - out_valid=1 and out_data = mem_rd_data (zero-latency read).
  - Address is held while out_valid & !out_ready, so out_data stays stable.
  - Handshake increments cnt. The last handshake (cnt==DUMP_LEN-1) returns to IDLE; out_valid is 0 next cycle.
- mem_wr_en is 0 outside LOAD. mem_addr is 0 in IDLE, REQ and WAIT, releasing the bus to the core.
- start outside IDLE is ignored; in_valid outside LOAD is ignored (no write, no count).
- Widths:
  - cnt width is AW+1; wd width is clog2(TIMEOUT)+1.
  - Address adds are AW bits.
  - Elaboration error if LOAD_BASE+LOAD_LEN > 2**AW, DUMP_BASE+DUMP_LEN > 2**AW, or TIMEOUT < 2.
- Load and dump ranges may overlap; no check is made.

Decomposition:
- Package mem_xfer_pkg:
  - state enum typedef (xfer_state_t: IDLE, LOAD, REQ, WAIT, DUMP).
  - Default parameter constants.
  - clog2-based width localparams.
- One sub-module, xfer_watchdog: counter with clear/enable inputs and an expired output, parameterised by TIMEOUT. All other logic stays in mem_xfer_ctrl.

Test Plan:
1. Full session: LOAD_LEN=4 at base 0, bytes 0x11,0x22,0x33,0x44 with in_valid always high -> writes at addr 0..3 on 4 consecutive cycles; cpu_req pulses exactly 1 cycle later; core model drops done, then raises it 10 cycles later -> DUMP reads addr 64..67 and out_data matches the memory model.
2. Backpressure: out_ready toggling 1,0,0,1 during dump -> out_data and mem_addr stable while stalled; exactly DUMP_LEN bytes emitted in order, no duplicates.
3. Load bubbles: in_valid deasserted on alternate cycles -> no mem_wr_en on idle cycles; addresses contiguous 0..LOAD_LEN-1.
4. Stale done: cpu_done held 1 throughout REQ and WAIT, TIMEOUT=16 -> no dump; timeout=1 after 16 WAIT cycles; busy=0; next start clears timeout.
5. Reset mid-LOAD after 2 bytes -> next cycle state IDLE, all outputs 0; a new start reloads from LOAD_BASE.
6. LOAD_LEN=0, DUMP_LEN=0 -> start gives REQ next cycle; done returns to IDLE with zero memory traffic.
